// File: rtl/local_injector.sv
// Local-port injector: turns a core packet request plus payload bytes into router flits,
// paced by a credit counter. Define LOCAL_INJECTOR_CHKSUM_EN to append an XOR checksum flit.
module local_injector #(
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_dst,
  input  logic [3:0] req_len,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic [7:0] data_in,
  input  logic       credit_ret,
  output logic [7:0] flit_out,
  output logic       flit_write,
  output logic       busy,
  output logic       credit_err
);

`ifdef LOCAL_INJECTOR_CHKSUM_EN
  typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} state_t;
  localparam state_t AFTER_DATA = TAIL;
`else
  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;
  localparam state_t AFTER_DATA = IDLE;
`endif

  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  state_t        state, state_nxt;
  logic [CW-1:0] credit_cnt, credit_nxt;
  logic [3:0]    pkt_dst, pkt_len, remaining;
  logic          has_credit, ret_ok, issue, capture, consume;
  logic [7:0]    issue_flit;
`ifdef LOCAL_INJECTOR_CHKSUM_EN
  logic [7:0]    chksum;
`endif

  assign has_credit = (credit_cnt != '0);
  assign busy       = (state != IDLE);
  // A return at full count is dropped so the counter saturates instead of wrapping.
  assign ret_ok     = credit_ret && (credit_cnt != CRED_MAX);
  assign credit_nxt = credit_cnt + CW'(ret_ok) - CW'(issue);

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    data_ready = 1'b0;
    issue      = 1'b0;
    issue_flit = '0;
    capture    = 1'b0;
    consume    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          capture   = 1'b1;
          state_nxt = HEAD;
        end
      end
      HEAD: begin
        if (has_credit) begin
          issue      = 1'b1;
          issue_flit = {pkt_dst, pkt_len};
          state_nxt  = (pkt_len == 4'd0) ? AFTER_DATA : BODY;
        end
      end
      BODY: begin
        data_ready = has_credit;
        if (data_valid && has_credit) begin
          issue      = 1'b1;
          issue_flit = data_in;
          consume    = 1'b1;
          if (remaining == 4'd1) state_nxt = AFTER_DATA;
        end
      end
`ifdef LOCAL_INJECTOR_CHKSUM_EN
      TAIL: begin
        if (has_credit) begin
          issue      = 1'b1;
          issue_flit = chksum;
          state_nxt  = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      credit_cnt <= CRED_MAX;
      flit_out   <= '0;
      flit_write <= 1'b0;
      credit_err <= 1'b0;
      pkt_dst    <= '0;
      pkt_len    <= '0;
      remaining  <= '0;
    end else begin
      state      <= state_nxt;
      credit_cnt <= credit_nxt;
      flit_write <= issue;
      if (issue) flit_out <= issue_flit;
      if (credit_ret && (credit_cnt == CRED_MAX)) credit_err <= 1'b1;
      if (capture) begin
        pkt_dst   <= req_dst;
        pkt_len   <= req_len;
        remaining <= req_len;
      end else if (consume) begin
        remaining <= remaining - 4'd1;
      end
    end
  end

`ifdef LOCAL_INJECTOR_CHKSUM_EN
  // Running XOR of every flit issued in the packet, head included.
  always_ff @(posedge Clk) begin
    if (Rst || capture) chksum <= '0;
    else if (issue)     chksum <= chksum ^ issue_flit;
  end
`endif

endmodule

// File: tb/tb_local_injector.sv
// Self-checking bench for local_injector: table-driven packets plus hand sequences,
// flits compared against a scoreboard queue filled when stimulus is prepared.
module tb_local_injector;
  localparam int CREDITS = 4;
`ifdef LOCAL_INJECTOR_CHKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic       Clk = 1'b0;
  logic       Rst, req_valid, req_ready, data_valid, data_ready, credit_ret;
  logic [3:0] req_dst, req_len;
  logic [7:0] data_in, flit_out;
  logic       flit_write, busy, credit_err;

  local_injector #(.CREDITS(CREDITS), .CW(3)) dut (
    .Clk(Clk), .Rst(Rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_dst(req_dst), .req_len(req_len),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .credit_ret(credit_ret), .flit_out(flit_out), .flit_write(flit_write),
    .busy(busy), .credit_err(credit_err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] dst;
    logic [3:0] len;
    logic [7:0] base;
    logic [7:0] exp_head;
    logic [7:0] exp_chk;
  } vec_t;
  vec_t vecs[5];

  logic [7:0] exp_q[$];
  logic [7:0] pl[16];
  logic [7:0] last_flit = 8'h00;
  int checks = 0, errors = 0;
  int cyc = 0, nwrites = 0, first_cyc = -1, last_cyc = 0, acc_cyc = 0;
  int exp_cnt = CREDITS, idx = 0, w0 = 0;
  bit auto_ret = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: inputs already driven; outputs sampled 1 time unit after the edge.
  task automatic step();
    logic ret_b;
    int   old;
    ret_b = credit_ret;
    @(posedge Clk);
    #1;
    cyc++;
    if (Rst) begin
      exp_cnt   = CREDITS;
      last_flit = 8'h00;
    end else begin
      old = exp_cnt;
      if (ret_b && old != CREDITS) exp_cnt++;
      if (flit_write) begin
        chk("issue_with_credit", int'(old > 0), 1);
        exp_cnt--;
      end
    end
    if (flit_write) begin
      nwrites++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_flit: got %0h expected none (cycle %0d)", flit_out, cyc);
      end else begin
        chk("flit", int'(flit_out), int'(exp_q.pop_front()));
      end
      last_flit = flit_out;
    end else begin
      chk("flit_hold", int'(flit_out), int'(last_flit));
    end
    if (auto_ret) credit_ret = flit_write;
  endtask

  task automatic cyc_drive(input bit dv);
    bit fire;
    data_valid = dv;
    data_in    = pl[idx];
    fire       = dv && data_ready;
    step();
    if (fire && idx < 15) idx++;
    data_in = pl[idx];
  endtask

  task automatic load(input logic [7:0] base);
    for (int i = 0; i < 16; i++) pl[i] = base + 8'(i * 17);
    idx = 0;
  endtask

  function automatic logic [7:0] xor_pkt(input logic [7:0] head, input int len);
    logic [7:0] x;
    x = head;
    for (int i = 0; i < len; i++) x = x ^ pl[i];
    return x;
  endfunction

  task automatic push_pkt(input int len, input logic [7:0] head, input logic [7:0] cks);
    exp_q.push_back(head);
    for (int i = 0; i < len; i++) exp_q.push_back(pl[i]);
    if (CHK != 0) exp_q.push_back(cks);
  endtask

  task automatic accept(input logic [3:0] dst, input logic [3:0] len);
    req_dst   = dst;
    req_len   = len;
    req_valid = 1'b1;
    chk("req_ready_idle", int'(req_ready), 1);
    first_cyc = -1;
    w0        = nwrites;
    step();
    acc_cyc   = cyc;
    req_valid = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
  endtask

  // Return one credit at a time until the stalled packet completes.
  task automatic drain(input string name);
    for (int n = 0; n < 40 && busy; n++) begin
      credit_ret = 1'b1;
      cyc_drive(1'b1);
      credit_ret = 1'b0;
      cyc_drive(1'b1);
    end
    chk({name, "_done"}, int'(busy), 0);
    chk({name, "_q_empty"}, exp_q.size(), 0);
  endtask

  task automatic restore();
    for (int n = 0; n < 8 && exp_cnt < CREDITS; n++) begin
      credit_ret = 1'b1;
      cyc_drive(1'b0);
    end
    credit_ret = 1'b0;
    cyc_drive(1'b0);
  endtask

  initial begin
    vecs[0] = '{4'h6, 4'd2,  8'h11, 8'h62, 8'h51};
    vecs[1] = '{4'hF, 4'd0,  8'h00, 8'hF0, 8'hF0};
    vecs[2] = '{4'h9, 4'd5,  8'h01, 8'h95, 8'hD4};
    vecs[3] = '{4'h0, 4'd1,  8'hFF, 8'h01, 8'hFE};
    vecs[4] = '{4'h3, 4'd3,  8'hA0, 8'h33, 8'hE0};

    Rst = 1'b1; req_valid = 1'b0; req_dst = '0; req_len = '0;
    data_valid = 1'b0; data_in = '0; credit_ret = 1'b0;
    load(8'h00);
    step();
    step();
    Rst = 1'b0;
    chk("rst_flit_write", int'(flit_write), 0);
    chk("rst_flit_out", int'(flit_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_data_ready", int'(data_ready), 0);
    chk("rst_credit_err", int'(credit_err), 0);

    // Table: credits returned the cycle after each flit, data always valid.
    for (int v = 0; v < 5; v++) begin
      int len;
      len = int'(vecs[v].len);
      load(vecs[v].base);
      auto_ret = 1'b1;
      push_pkt(len, vecs[v].exp_head, vecs[v].exp_chk);
      accept(vecs[v].dst, vecs[v].len);
      for (int n = 0; n < 60 && busy; n++) cyc_drive(1'b1);
      chk("busy_falls_on_last_flit", int'(flit_write), 1);
      chk("vec_busy_done", int'(busy), 0);
      chk("vec_q_empty", exp_q.size(), 0);
      chk("vec_head_latency", first_cyc - acc_cyc, 1);
      chk("vec_flit_count", nwrites - w0, 1 + len + CHK);
      chk("vec_back_to_back", last_cyc - first_cyc, len + CHK);
      cyc_drive(1'b0);
      auto_ret = 1'b0;
      credit_ret = 1'b0;
      cyc_drive(1'b0);
    end

    // Credit stall: len 6 with no returns, then one flit per returned credit.
    load(8'h30);
    push_pkt(6, 8'hA6, xor_pkt(8'hA6, 6));
    accept(4'hA, 4'd6);
    repeat (12) cyc_drive(1'b1);
    chk("stall_flits", nwrites - w0, 4);
    chk("stall_data_ready", int'(data_ready), 0);
    chk("stall_busy", int'(busy), 1);
    for (int p = 0; p < 3 + CHK; p++) begin
      w0 = nwrites;
      credit_ret = 1'b1;
      cyc_drive(1'b1);
      credit_ret = 1'b0;
      repeat (4) cyc_drive(1'b1);
      chk("pulse_release", nwrites - w0, 1);
    end
    chk("stall_done", int'(busy), 0);
    chk("stall_q_empty", exp_q.size(), 0);
    restore();

    // Return coincident with an issue at count 1 keeps the count at 1.
    load(8'h40);
    push_pkt(5, 8'h55, xor_pkt(8'h55, 5));
    accept(4'h5, 4'd5);
    repeat (3) cyc_drive(1'b1);
    credit_ret = 1'b1;
    cyc_drive(1'b1);
    credit_ret = 1'b0;
    chk("coincident_issue", int'(flit_write), 1);
    cyc_drive(1'b1);
    chk("next_after_coincident", int'(flit_write), 1);
    chk("coincident_then_empty", int'(data_ready), 0);
    cyc_drive(1'b1);
    chk("no_issue_at_zero", int'(flit_write), 0);
    drain("coincident");
    restore();

    // Return at full count: sticky error, counter must not exceed CREDITS.
    chk("err_before", int'(credit_err), 0);
    credit_ret = 1'b1;
    cyc_drive(1'b0);
    credit_ret = 1'b0;
    chk("err_set", int'(credit_err), 1);
    repeat (3) cyc_drive(1'b0);
    chk("err_sticky", int'(credit_err), 1);
    load(8'hC3);
    push_pkt(4, 8'h24, xor_pkt(8'h24, 4));
    accept(4'h2, 4'd4);
    repeat (10) cyc_drive(1'b1);
    chk("saturated_flits", nwrites - w0, 4);
    drain("saturated");
    restore();
    chk("err_still_sticky", int'(credit_err), 1);

    // Reset after one of five body flits abandons the packet.
    load(8'h70);
    exp_q.push_back(8'hC5);
    exp_q.push_back(pl[0]);
    accept(4'hC, 4'd5);
    cyc_drive(1'b1);
    cyc_drive(1'b1);
    Rst = 1'b1;
    cyc_drive(1'b1);
    Rst = 1'b0;
    chk("midrst_flit_write", int'(flit_write), 0);
    chk("midrst_flit_out", int'(flit_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_req_ready", int'(req_ready), 1);
    chk("midrst_credit_err", int'(credit_err), 0);
    chk("midrst_q_empty", exp_q.size(), 0);
    load(8'h10);
    push_pkt(3, 8'h23, xor_pkt(8'h23, 3));
    accept(4'h2, 4'd3);
    repeat (8) cyc_drive(1'b1);
    chk("postrst_flits", nwrites - w0, 4);
    chk("postrst_head_latency", first_cyc - acc_cyc, 1);
    drain("postrst");
    restore();

    // data_valid toggling in BODY issues only on valid cycles, order kept.
    load(8'h5A);
    auto_ret = 1'b1;
    push_pkt(4, 8'h44, xor_pkt(8'h44, 4));
    accept(4'h4, 4'd4);
    cyc_drive(1'b0);
    chk("toggle_head", int'(flit_write), 1);
    for (int i = 0; i < 8; i++) begin
      bit dv;
      dv = ((i % 2) == 0);
      cyc_drive(dv);
      chk("toggle_write", int'(flit_write), (i == 7 && CHK != 0) ? 1 : int'(dv));
    end
    chk("toggle_done", int'(busy), 0);
    chk("toggle_q_empty", exp_q.size(), 0);
    cyc_drive(1'b0);
    auto_ret = 1'b0;
    credit_ret = 1'b0;
    cyc_drive(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
